// File: rtl/fir_tdm_mac.sv
// fir_tdm_mac: multi-channel FIR sharing one MAC, with loadable taps and per-tap product truncation.
// Optional macro FIR_TDM_SAT_EN makes the output saturate; by default it wraps.
module fir_tdm_mac #(
    parameter int NUM_TAPS    = 15,
    parameter int NUM_CH      = 2,
    parameter int COE_INTE_WL = 4,
    parameter int COE_FRAC_WL = 8,
    parameter int IN_INTE_WL  = 4,
    parameter int IN_FRAC_WL  = 8,
    parameter int OUT_INTE_WL = 4,
    parameter int OUT_FRAC_WL = 8,
    parameter int ACC_FRAC_WL = 12,
    parameter int PRODUCT_FRAC_WL_ARRAY [0:NUM_TAPS-1] =
        '{12, 11, 11, 12, 11, 9, 10, 10, 11, 8, 9, 9, 10, 11, 10}
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [IN_INTE_WL+IN_FRAC_WL-1:0]            data_in,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] in_ch,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic                                        coe_we,
    input  logic [((NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1)-1:0] coe_addr,
    input  logic [COE_INTE_WL+COE_FRAC_WL-1:0]          coe_data,
    output logic                                        coe_err,
    output logic [OUT_INTE_WL+OUT_FRAC_WL-1:0]          data_out,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] out_ch,
    output logic                                        out_valid
);

    localparam int COE_W    = COE_INTE_WL + COE_FRAC_WL;
    localparam int IN_W     = IN_INTE_WL + IN_FRAC_WL;
    localparam int OUT_W    = OUT_INTE_WL + OUT_FRAC_WL;
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int K_W      = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam int PRD_W    = COE_W + IN_W;
    localparam int PRD_FRAC = COE_FRAC_WL + IN_FRAC_WL;
    localparam int ACC_W    = COE_INTE_WL + IN_INTE_WL + $clog2(NUM_TAPS)
                              + ACC_FRAC_WL;
    localparam int EXT_W    = ACC_W + PRD_W;
    localparam int OUT_SH   = ACC_FRAC_WL - OUT_FRAC_WL;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_OUT
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic signed [IN_W-1:0]    r_dly  [NUM_CH][NUM_TAPS];
    logic signed [COE_W-1:0]   r_coef [NUM_TAPS];
    logic signed [ACC_W-1:0]   r_acc;
    logic [K_W-1:0]            r_k;
    logic [CH_W-1:0]           r_ch;
    logic                      r_live;
    logic [OUT_W-1:0]          r_dout;
    logic [CH_W-1:0]           r_out_ch;
    logic                      r_out_valid;
    logic                      r_coe_err;

    logic                      w_accept;
    logic                      w_ch_ok;
    logic                      w_coe_ok;
    logic                      w_coe_wr;
    logic signed [PRD_W-1:0]   w_prod;
    logic [7:0]                w_sh_r;
    logic [7:0]                w_sh_l;
    logic signed [ACC_W-1:0]   w_term;
    logic [OUT_W-1:0]          w_dout;

    assign in_ready  = r_live & (r_state == S_IDLE);
    assign coe_err   = r_coe_err;
    assign data_out  = r_dout;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;

    assign w_accept = in_valid & in_ready;
    assign w_ch_ok  = int'(in_ch) < NUM_CH;
    assign w_coe_ok = int'(coe_addr) < NUM_TAPS;
    assign w_coe_wr = coe_we & w_coe_ok & (r_state == S_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_accept && w_ch_ok) begin
                    w_state_nxt = S_MAC;
                end
            end
            S_MAC: begin
                if (r_k == K_W'(NUM_TAPS - 1)) begin
                    w_state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Floor the product to this tap's fraction length, then align to the accumulator.
    assign w_prod = PRD_W'(r_coef[r_k]) * PRD_W'(r_dly[r_ch][r_k]);

    always_comb begin
        w_sh_r = 8'(PRD_FRAC - PRODUCT_FRAC_WL_ARRAY[r_k]);
        w_sh_l = 8'(ACC_FRAC_WL - PRODUCT_FRAC_WL_ARRAY[r_k]);
        w_term = ACC_W'((EXT_W'(w_prod) >>> w_sh_r) <<< w_sh_l);
    end

`ifdef FIR_TDM_SAT_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W-1:0]   w_q;

    always_comb begin
        w_q = r_acc >>> OUT_SH;
        if (w_q > OUT_MAX) begin
            w_dout = OUT_MAX[OUT_W-1:0];
        end else if (w_q < OUT_MIN) begin
            w_dout = OUT_MIN[OUT_W-1:0];
        end else begin
            w_dout = w_q[OUT_W-1:0];
        end
    end
`else
    assign w_dout = r_acc[OUT_SH +: OUT_W];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_live      <= 1'b0;
            r_k         <= '0;
            r_ch        <= '0;
            r_acc       <= '0;
            r_dout      <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_coe_err   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                for (int t = 0; t < NUM_TAPS; t++) begin
                    r_dly[c][t] <= '0;
                end
            end
            for (int t = 0; t < NUM_TAPS; t++) begin
                r_coef[t] <= '0;
            end
        end else begin
            r_live      <= 1'b1;
            r_out_valid <= 1'b0;
            r_coe_err   <= coe_we & ~w_coe_wr;
            if (w_coe_wr) begin
                r_coef[coe_addr] <= coe_data;
            end
            if (w_accept && w_ch_ok) begin
                r_dly[in_ch][0] <= data_in;
                for (int t = NUM_TAPS - 1; t > 0; t--) begin
                    r_dly[in_ch][t] <= r_dly[in_ch][t-1];
                end
                r_ch  <= in_ch;
                r_acc <= '0;
                r_k   <= '0;
            end
            if (r_state == S_MAC) begin
                r_acc <= r_acc + w_term;
                r_k   <= r_k + K_W'(1);
            end
            if (r_state == S_OUT) begin
                r_dout      <= w_dout;
                r_out_ch    <= r_ch;
                r_out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_tdm_mac.sv
// tb_fir_tdm_mac: directed bench for fir_tdm_mac with an output scoreboard.
// Expected outputs come from directed constants or a floor-division reference model.
module tb_fir_tdm_mac;

    localparam int PFW [15] = '{12, 11, 11, 12, 11, 9, 10, 10, 11, 8, 9, 9, 10, 11, 10};

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] data_in;
    logic [0:0]  in_ch;
    logic        in_valid;
    logic        in_ready;
    logic        coe_we;
    logic [3:0]  coe_addr;
    logic [11:0] coe_data;
    logic        coe_err;
    logic [11:0] data_out;
    logic [0:0]  out_ch;
    logic        out_valid;

    typedef struct {
        logic [11:0] d;
        logic [0:0]  ch;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ov_cnt = 0;
    int   m_coef [15];
    int   m_dly  [2][15];

    fir_tdm_mac dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .in_ch     (in_ch),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coe_we    (coe_we),
        .coe_addr  (coe_addr),
        .coe_data  (coe_data),
        .coe_err   (coe_err),
        .data_out  (data_out),
        .out_ch    (out_ch),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic longint fdiv(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int model_out(input int ch);
        longint acc;
        longint p;
        longint q;
        acc = 0;
        for (int k = 0; k < 15; k++) begin
            p = longint'(m_coef[k]) * longint'(m_dly[ch][k]);
            acc = acc + fdiv(p, longint'(1) << (16 - PFW[k])) * (longint'(1) << (12 - PFW[k]));
        end
        q = fdiv(acc, 16);
`ifdef FIR_TDM_SAT_EN
        if (q > 2047) q = 2047;
        if (q < -2048) q = -2048;
`else
        q = ((q % 4096) + 4096) % 4096;
        if (q >= 2048) q = q - 4096;
`endif
        return int'(q);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            ov_cnt++;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_out: observed data %0d with no expected entry", $signed(data_out));
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("data_out", {20'b0, data_out}, {20'b0, e.d});
                chk("out_ch", {31'b0, out_ch}, {31'b0, e.ch});
                chk("latency", cyc - e.cyc, 17);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("ready_timeout", {31'b0, in_ready}, 1);
    endtask

    task automatic wcoe(input int a, input int v);
        wait_ready();
        coe_we   = 1'b1;
        coe_addr = 4'(a);
        coe_data = 12'(v);
        if (a < 15) m_coef[a] = v;
        @(negedge clk);
        coe_we = 1'b0;
        chk("wr_no_err", {31'b0, coe_err}, 0);
    endtask

    task automatic send(input int ch, input int d, input bit push, input bit dir, input int exp_v);
        exp_t e;
        wait_ready();
        in_valid = 1'b1;
        in_ch    = 1'(ch);
        data_in  = 12'(d);
        for (int t = 14; t > 0; t--) m_dly[ch][t] = m_dly[ch][t-1];
        m_dly[ch][0] = d;
        if (push) begin
            e.d   = dir ? 12'(exp_v) : 12'(model_out(ch));
            e.ch  = 1'(ch);
            e.cyc = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ov0;
        rst      = 1'b0;
        data_in  = '0;
        in_ch    = '0;
        in_valid = 1'b0;
        coe_we   = 1'b0;
        coe_addr = '0;
        coe_data = '0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 0);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_data_out", {20'b0, data_out}, 0);
        chk("rst_out_ch", {31'b0, out_ch}, 0);
        chk("rst_coe_err", {31'b0, coe_err}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {31'b0, in_ready}, 1);

        for (int k = 0; k < 15; k++) wcoe(k, k + 1);

        send(0, 256, 1, 1, 1);
        for (int n = 1; n < 15; n++) send(0, 0, 1, 1, n + 1);
        drain();

        send(0, 0, 1, 0, 0);
        for (int n = 0; n < 5; n++) begin
            send(0, (n == 0) ? 256 : 0, 1, 1, n + 1);
            send(1, 0, 1, 1, 0);
        end
        drain();

        send(0, 256, 1, 0, 0);
        coe_we   = 1'b1;
        coe_addr = 4'd0;
        coe_data = 12'd100;
        @(negedge clk);
        coe_we = 1'b0;
        chk("busy_err", {31'b0, coe_err}, 1);
        @(negedge clk);
        chk("busy_err_once", {31'b0, coe_err}, 0);
        drain();
        send(1, 256, 1, 1, 1);
        drain();

        wait_ready();
        coe_we   = 1'b1;
        coe_addr = 4'd15;
        coe_data = 12'd5;
        @(negedge clk);
        coe_we = 1'b0;
        chk("bad_addr_err", {31'b0, coe_err}, 1);
        @(negedge clk);
        chk("bad_addr_once", {31'b0, coe_err}, 0);

        for (int k = 0; k < 15; k++) wcoe(k, (k == 9) ? 1 : 0);
        send(0, 1, 1, 0, 0);
        for (int n = 1; n < 9; n++) send(0, 0, 1, 0, 0);
        send(0, 0, 1, 1, 0);
        send(0, -1, 1, 0, 0);
        for (int n = 1; n < 9; n++) send(0, 0, 1, 0, 0);
        send(0, 0, 1, 1, -1);
        drain();

        for (int k = 0; k < 15; k++) wcoe(k, 2047);
        for (int n = 0; n < 14; n++) send(1, 2047, 1, 0, 0);
`ifdef FIR_TDM_SAT_EN
        send(1, 2047, 1, 1, 2047);
`else
        send(1, 2047, 1, 0, 0);
`endif
        for (int n = 0; n < 14; n++) send(1, -2048, 1, 0, 0);
`ifdef FIR_TDM_SAT_EN
        send(1, -2048, 1, 1, -2048);
`else
        send(1, -2048, 1, 0, 0);
`endif
        drain();

        send(0, 256, 0, 0, 0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        ov0 = ov_cnt;
        @(negedge clk);
        chk("midrst_in_ready", {31'b0, in_ready}, 0);
        chk("midrst_out_valid", {31'b0, out_valid}, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 15; k++) m_coef[k] = 0;
        for (int c = 0; c < 2; c++)
            for (int t = 0; t < 15; t++) m_dly[c][t] = 0;
        @(negedge clk);
        chk("midrst_ready_rise", {31'b0, in_ready}, 1);
        repeat (20) @(negedge clk);
        chk("midrst_no_out", ov_cnt, ov0);
        send(0, 256, 1, 1, 0);
        send(0, 0, 1, 1, 0);
        send(1, 256, 1, 1, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
